// File: rtl/sec1_pkg.sv
// Shared constants and state encoding for the SEC1 point encoder.
// Prefix bytes, frame lengths and the FSM state type.
package sec1_pkg;

    localparam logic [7:0] SEC1_PFX_INF  = 8'h00;
    localparam logic [7:0] SEC1_PFX_EVEN = 8'h02;
    localparam logic [7:0] SEC1_PFX_ODD  = 8'h03;
    localparam logic [7:0] SEC1_PFX_UNC  = 8'h04;

    localparam int unsigned SEC1_LEN_COMP = 33;
    localparam int unsigned SEC1_LEN_UNC  = 65;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        XB,
        YB,
        FINISH
    } sec1_state_e;

endpackage

// File: rtl/sec1_point_encoder.sv
// Serialises an affine point as a SEC1 octet string over a byte-wide valid/ready stream.
// Frames are started by a rising edge of start; all outputs are registered.
module sec1_point_encoder
    import sec1_pkg::*;
#(
    parameter int unsigned COORD_W = 256,
    parameter int unsigned BYTE_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               compress,
    input  logic               infinity,
    input  logic [COORD_W-1:0] x_affine,
    input  logic [COORD_W-1:0] y_affine,
    output logic [BYTE_W-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NBYTES = COORD_W / BYTE_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES);
    localparam int unsigned IDX_W  = $clog2(COORD_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    sec1_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               start_q;
    logic               comp_q;
    logic               inf_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    logic [COORD_W-1:0] sel_src;
    logic [CNT_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   sel_base;
    logic [BYTE_W-1:0]  next_byte;

    assign cnt_nxt = cnt + 1'b1;

    // Byte that follows the one currently on the bus, used when a handshake advances the frame.
    always_comb begin
        sel_src = x_q;
        sel_idx = '0;
        case (state)
            XB: begin
                if (cnt == LAST) begin
                    sel_src = y_q;
                end else begin
                    sel_idx = cnt_nxt;
                end
            end
            YB: begin
                sel_src = y_q;
                sel_idx = cnt_nxt;
            end
            default: ;
        endcase
        sel_base  = IDX_W'(COORD_W - 1) - IDX_W'(sel_idx) * IDX_W'(BYTE_W);
        next_byte = sel_src[sel_base -: BYTE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            start_q  <= 1'b0;
            comp_q   <= 1'b0;
            inf_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !start_q) begin
                        x_q      <= x_affine;
                        y_q      <= y_affine;
                        comp_q   <= compress;
                        inf_q    <= infinity;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        m_tvalid <= 1'b1;
                        m_tlast  <= infinity;
                        state    <= PREFIX;
                        if (infinity) begin
                            m_tdata <= SEC1_PFX_INF;
                        end else if (compress) begin
                            m_tdata <= y_affine[0] ? SEC1_PFX_ODD : SEC1_PFX_EVEN;
                        end else begin
                            m_tdata <= SEC1_PFX_UNC;
                        end
                    end
                end
                PREFIX: begin
                    if (m_tready) begin
                        if (inf_q) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            cnt     <= '0;
                            m_tdata <= next_byte;
                            m_tlast <= 1'b0;
                            state   <= XB;
                        end
                    end
                end
                XB: begin
                    if (m_tready) begin
                        if (cnt != LAST) begin
                            cnt     <= cnt_nxt;
                            m_tdata <= next_byte;
                            m_tlast <= comp_q && (cnt_nxt == LAST);
                        end else if (comp_q) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            cnt     <= '0;
                            m_tdata <= next_byte;
                            m_tlast <= 1'b0;
                            state   <= YB;
                        end
                    end
                end
                YB: begin
                    if (m_tready) begin
                        if (cnt != LAST) begin
                            cnt     <= cnt_nxt;
                            m_tdata <= next_byte;
                            m_tlast <= (cnt_nxt == LAST);
                        end else begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sec1_point_encoder.sv
// Self-checking bench for sec1_point_encoder: directed frames with random data and backpressure
// compared against a byte-queue model of the SEC1 encoding rules.
module tb_sec1_point_encoder;

    localparam logic [255:0] G_X =
        256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] G_Y =
        256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam int LIM = 300;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         compress;
    logic         infinity;
    logic [255:0] x_affine;
    logic [255:0] y_affine;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         busy;
    logic         done;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    sec1_point_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .compress (compress),
        .infinity (infinity),
        .x_affine (x_affine),
        .y_affine (y_affine),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Reference: the octet string is a prefix followed by big-endian coordinate bytes.
    function automatic void build_expected(input bit comp, input bit inf,
                                           input logic [255:0] x, input logic [255:0] y);
        logic [255:0] t;
        exp_q.delete();
        if (inf) begin
            exp_q.push_back(8'h00);
            return;
        end
        exp_q.push_back(comp ? (8'h02 + {7'd0, y[0]}) : 8'h04);
        t = x;
        repeat (32) begin
            exp_q.push_back(t[255:248]);
            t = t << 8;
        end
        if (!comp) begin
            t = y;
            repeat (32) begin
                exp_q.push_back(t[255:248]);
                t = t << 8;
            end
        end
    endfunction

    // rmode: 0 = ready always high, 1 = random ready.
    // smode: 0 = single start pulse, 1 = start held 200 cycles, 2 = extra pulse while in XB.
    task automatic run_frame(input string name, input bit comp, input bit inf,
                             input logic [255:0] x, input logic [255:0] y,
                             input int rmode, input int smode);
        int len, hs, last_hs, dones;
        bit stalled, held_last, r;
        logic [7:0] held;
        build_expected(comp, inf, x, y);
        len = exp_q.size();
        hs = 0; last_hs = -10; dones = 0; stalled = 0; held = '0; held_last = 0;
        @(negedge clk);
        x_affine = x; y_affine = y; compress = comp; infinity = inf; start = 1'b1;
        m_tready = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= LIM; k++) begin
            @(negedge clk);
            if (smode == 1) start = (k < 200);
            else if (smode == 2) start = (k == 10);
            else start = 1'b0;
            if (k == 3) begin
                x_affine = rand256(); y_affine = rand256();
                compress = ~comp; infinity = ~inf;
            end
            if (stalled) begin
                check({name, "_stall_valid"}, m_tvalid, 1'b1);
                check({name, "_stall_data"}, m_tdata, held);
                check({name, "_stall_last"}, m_tlast, held_last);
            end
            if (m_tvalid) begin
                if (hs < len) begin
                    check($sformatf("%s_byte%0d", name, hs), m_tdata, exp_q[hs]);
                    check($sformatf("%s_last%0d", name, hs), m_tlast, (hs == len - 1));
                end else begin
                    check({name, "_extra_beat"}, m_tvalid, 1'b0);
                end
            end
            check({name, "_busy"}, busy, (hs < len) || (k == last_hs + 1));
            if (done) begin
                dones++;
                check({name, "_done_time"}, k, last_hs + 1);
            end
            r = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready = r;
            if (m_tvalid && r) begin
                hs++;
                if (hs == len) last_hs = k;
                stalled = 1'b0;
            end else begin
                stalled = m_tvalid;
                held = m_tdata;
                held_last = m_tlast;
            end
        end
        start = 1'b0;
        check({name, "_handshakes"}, hs, len);
        check({name, "_done_count"}, dones, 1);
        if (rmode == 0) check({name, "_last_hs_cycle"}, last_hs, len);
    endtask

    initial begin
        logic [255:0] ry;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; compress = 1'b0; infinity = 1'b0;
        x_affine = '0; y_affine = '0; m_tready = 1'b0;
        #1;
        check("rst_tdata", m_tdata, 8'h00);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_frame("g_comp", 1'b1, 1'b0, G_X, G_Y, 0, 0);
        run_frame("g_unc", 1'b0, 1'b0, G_X, G_Y, 0, 0);
        ry = rand256(); ry[0] = 1'b1;
        run_frame("odd_comp", 1'b1, 1'b0, rand256(), ry, 0, 0);
        run_frame("inf", 1'b0, 1'b1, rand256(), rand256(), 0, 0);
        run_frame("g_unc_bp", 1'b0, 1'b0, G_X, G_Y, 1, 0);
        run_frame("rnd_comp_bp", 1'b1, 1'b0, rand256(), rand256(), 1, 0);
        run_frame("held_start", 1'b0, 1'b0, G_X, G_Y, 0, 1);
        run_frame("pulse_in_xb", 1'b0, 1'b0, G_X, G_Y, 0, 2);

        // Reset in the middle of an uncompressed frame, after 20 bytes have gone out.
        build_expected(1'b0, 1'b0, G_X, G_Y);
        @(negedge clk);
        x_affine = G_X; y_affine = G_Y; compress = 1'b0; infinity = 1'b0;
        m_tready = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_byte20", m_tdata, exp_q[20]);
        check("mid_valid", m_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_tvalid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tlast", m_tlast, 1'b0);
        check("mid_rst_tdata", m_tdata, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_done", done, 1'b0);
        end
        rst_n = 1'b1;
        run_frame("after_rst", 1'b0, 1'b0, G_X, G_Y, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
